adc_decimator: RTL and testbench
================================

# adc_decimator

Boxcar decimator placed directly downstream of the 16-bit bipolar ADC. It takes 16-bit two's-complement conversion samples on a valid strobe and averages each non-overlapping window of 2^DECIM_LOG2 samples. Each average goes into a 2-entry output buffer with a valid/ready handshake. Optionally, it accumulates a bit-toggle "charge" figure for power estimation.

## Interface
- DECIM_LOG2, 3: log2 of window length N; legal range 1..6.
- CHARGE_LIMIT, 1000000: charge_ovr sets when charge exceeds this value.
- CHARGE_WEIGHT, 3: charge units added per toggled input bit.

- clk  input  1  rising-edge clock.
- reset_charge  input  1  reset, asynchronous, active-high.
- sample_in  input  16  ADC sample, two's complement (-32768..+32767).
- sample_valid  input  1  sample_in valid this cycle; single-cycle strobe per sample.
- out_data  output  16  window average, two's complement.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  consumer accepts out_data when high with out_valid.
- out_overrun  output  1  sticky; a result was dropped because the buffer was full.
- charge  output  20  accumulated toggle charge.
- charge_ovr  output  1  sticky; charge > CHARGE_LIMIT.

## Operation
- Accumulator: signed, 16+DECIM_LOG2 bits; it cannot overflow for any input sequence.
- Sample counter: DECIM_LOG2 bits, counts 0..N-1.
- On each sample_valid:
  - If count < N-1: acc += sext(sample_in) and count++.
  - If count == N-1: result = (acc + sext(sample_in)) >>> DECIM_LOG2 (arithmetic shift, floor toward -inf), truncated to 16 bits. Push result, then set acc=0, count=0.
- Output buffer: 2-entry FIFO. Its states are EMPTY, ONE and FULL.
  - Push in EMPTY -> ONE. Push in ONE -> FULL.
  - Pop in ONE -> EMPTY. Pop in FULL -> ONE.
  - Push and pop together: count unchanged, order preserved.
  - Push in FULL without a pop: result discarded, out_overrun set, buffer contents untouched.
  - Push in FULL with a pop in the same cycle: accepted, no drop.
- Pop occurs when out_valid && out_ready.
- out_valid = (state != EMPTY). out_data = head entry.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Charge accounting (see Configuration), on each sample_valid:
  - toggles = popcount(sample_in ^ prev_sample). prev_sample is then updated.
  - charge += toggles*CHARGE_WEIGHT, saturating at 20'hFFFFF.
  - charge_ovr sets when the updated charge > CHARGE_LIMIT. It is cleared only by reset.
- Reset value of every output: out_data=0, out_valid=0, out_overrun=0, charge=0, charge_ovr=0.
- Reset value of internal state: acc=0, count=0, prev_sample=0, FIFO EMPTY.
- Reset mid-window discards the partial sum and any buffered results. The next sample after release starts a new window at count 0.

## Timing
- Result latency: out_valid rises on the clock edge that samples the N-th sample_valid. It is visible in the following cycle.
- Throughput: one sample per cycle sustained.
- charge and charge_ovr update on the same edge as the sample that caused the change.
- out_overrun sets on the edge of the dropped push.
- reset_charge asserts asynchronously. Deassertion must be synchronous to clk (externally synchronized).

## Configuration
- ADC_DECIMATOR_CHARGE_EN defined: the charge path (prev_sample register, popcount, saturating adder, charge_ovr) is compiled in as described above.
- Not defined: charge and charge_ovr are tied to 0, and no charge logic is generated. Decimation behaviour is identical in both builds.

## Test plan
- All tests use N=8 unless stated.
- Averaging: 8 samples of 16'h0100, out_ready=1 -> one result 16'h0100, with out_valid high for exactly 1 cycle.
- Floor rounding: 7× 16'h0000 then 1× 16'hFFFF -> result 16'hFFFF (floor of -1/8). Extremes: 8× 16'h7FFF -> 16'h7FFF; 8× 16'h8000 -> 16'h8000.
- Backpressure: out_ready=0 over 3 windows with values 1, 2, 3 (16'h0001, 16'h0002, 16'h0003):
  - Expected: FULL holding 1 then 2; third result dropped; out_overrun=1.
  - Then raise out_ready: pops 1 then 2, out_valid falls.
  - Repeat with out_ready pulsed in the same cycle as the third push: no drop.
- Charge (macro defined): samples 16'h0000, 16'hFFFF, 16'h0000 -> charge 0, 48, 96.
  - Drive 16'h0000/16'hFFFF alternately for 20834 samples from reset -> charge_ovr set when charge first exceeds 1000000.
  - Continue driving -> charge saturates at 20'hFFFFF.
- Reset mid-operation: assert reset_charge after 5 samples with one result buffered -> all outputs 0 immediately. After release, 8 samples of 16'h0010 -> single result 16'h0010.
- Macro undefined: rerun the charge test -> charge=0 and charge_ovr=0 throughout; averaging test results unchanged.

Source files
------------

// File: rtl/adc_decimator_if.sv
// Sample-in / result-out bundle for adc_decimator.
// master: the ADC front end plus result consumer (drives samples and ready).
// slave:  the decimator itself.
interface adc_decimator_if;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_overrun;
   logic [19:0] charge;
   logic        charge_ovr;

   modport master (
      output sample_in,
      output sample_valid,
      output out_ready,
      input  out_data,
      input  out_valid,
      input  out_overrun,
      input  charge,
      input  charge_ovr
   );

   modport slave (
      input  sample_in,
      input  sample_valid,
      input  out_ready,
      output out_data,
      output out_valid,
      output out_overrun,
      output charge,
      output charge_ovr
   );
endinterface

// File: rtl/adc_decimator.sv
// Boxcar decimator for the 16-bit bipolar ADC: averages non-overlapping windows of
// 2^DECIM_LOG2 samples (floor rounding) into a 2-entry valid/ready output buffer.
// Optional bit-toggle charge accounting is compiled in when ADC_DECIMATOR_CHARGE_EN
// is defined; otherwise charge/charge_ovr are tied low.
module adc_decimator #(
   parameter int unsigned DECIM_LOG2    = 3,
   parameter int unsigned CHARGE_LIMIT  = 1000000,
   parameter int unsigned CHARGE_WEIGHT = 3
) (
   input logic            clk_i,
   input logic            reset_charge,
   adc_decimator_if.slave dec_io
);

   // Window sum of N 16-bit samples needs 16+log2(N) bits, so it can never overflow.
   localparam int unsigned AccW = 16 + DECIM_LOG2;

   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StOne   = 2'd1;
   localparam logic [1:0] StFull  = 2'd2;

   logic signed [AccW-1:0] acc_q, acc_d;
   logic signed [AccW-1:0] sample_sext;
   logic signed [AccW-1:0] sum;
   logic signed [AccW-1:0] shifted;
   logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
   logic                   window_done;
   logic [15:0]            result;

   logic [1:0]  state_q, state_d;
   logic [15:0] head_q, head_d;
   logic [15:0] tail_q, tail_d;
   logic        overrun_q, overrun_d;
   logic        push;
   logic        pop;

   assign sample_sext = {{DECIM_LOG2{dec_io.sample_in[15]}}, dec_io.sample_in};
   assign sum         = acc_q + sample_sext;
   assign shifted     = sum >>> DECIM_LOG2;
   assign result      = shifted[15:0];
   assign window_done = dec_io.sample_valid && (cnt_q == {DECIM_LOG2{1'b1}});

   assign push = window_done;
   assign pop  = (state_q != StEmpty) && dec_io.out_ready;

   // Accumulator and sample counter next state.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (dec_io.sample_valid) begin
         if (window_done) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Accumulator and sample counter registers.
   always_ff @(posedge clk_i or posedge reset_charge) begin
      if (reset_charge) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   // Output buffer next state; head is always the entry presented on out_data.
   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      overrun_d = overrun_q;
      case (state_q)
         StEmpty: begin
            if (push) begin
               head_d  = result;
               state_d = StOne;
            end
         end
         StOne: begin
            if (push && pop) begin
               head_d = result;
            end else if (push) begin
               tail_d  = result;
               state_d = StFull;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = StOne;
               if (push) begin
                  tail_d  = result;
                  state_d = StFull;
               end
            end else if (push) begin
               // No room and nobody draining: drop the new result, keep contents.
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = StEmpty;
         end
      endcase
   end

   // Output buffer registers.
   always_ff @(posedge clk_i or posedge reset_charge) begin
      if (reset_charge) begin
         state_q   <= StEmpty;
         head_q    <= '0;
         tail_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         overrun_q <= overrun_d;
      end
   end

   assign dec_io.out_data    = head_q;
   assign dec_io.out_valid   = (state_q != StEmpty);
   assign dec_io.out_overrun = overrun_q;

`ifdef ADC_DECIMATOR_CHARGE_EN
   localparam logic [32:0] ChargeMax = 33'h0_000F_FFFF;

   logic [15:0] prev_q, prev_d;
   logic [19:0] charge_q, charge_d;
   logic        ovr_q, ovr_d;
   logic [4:0]  toggles;
   logic [15:0] diff;
   logic [31:0] incr;
   logic [32:0] total;

   assign diff = dec_io.sample_in ^ prev_q;

   // Count of input bits that flipped since the previous sample.
   always_comb begin
      toggles = '0;
      for (int i = 0; i < 16; i++) begin
         toggles = toggles + {4'd0, diff[i]};
      end
   end

   assign incr  = {27'd0, toggles} * CHARGE_WEIGHT;
   assign total = {13'd0, charge_q} + {1'b0, incr};

   // Saturating charge update and sticky limit flag.
   always_comb begin
      prev_d   = prev_q;
      charge_d = charge_q;
      ovr_d    = ovr_q;
      if (dec_io.sample_valid) begin
         prev_d   = dec_io.sample_in;
         charge_d = (total > ChargeMax) ? 20'hF_FFFF : total[19:0];
         if ({12'd0, charge_d} > CHARGE_LIMIT) begin
            ovr_d = 1'b1;
         end
      end
   end

   // Charge registers.
   always_ff @(posedge clk_i or posedge reset_charge) begin
      if (reset_charge) begin
         prev_q   <= '0;
         charge_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         charge_q <= charge_d;
         ovr_q    <= ovr_d;
      end
   end

   assign dec_io.charge     = charge_q;
   assign dec_io.charge_ovr = ovr_q;
`else
   assign dec_io.charge     = '0;
   assign dec_io.charge_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_adc_decimator.sv
// Directed bench for adc_decimator (N=8). A queue-based model of the window average,
// output buffer and charge figure is compared against the DUT every cycle; directed
// literal checks pin the model to hand-computed values.
module tb_adc_decimator;

   localparam int N     = 8;
   localparam int LIMIT = 1000000;
   localparam int WGT   = 3;
`ifdef ADC_DECIMATOR_CHARGE_EN
   localparam bit ChEn = 1'b1;
`else
   localparam bit ChEn = 1'b0;
`endif

   logic clk;
   logic rst;

   adc_decimator_if dec_if ();

   adc_decimator #(
      .DECIM_LOG2    (3),
      .CHARGE_LIMIT  (LIMIT),
      .CHARGE_WEIGHT (WGT)
   ) u_dut (
      .clk_i        (clk),
      .reset_charge (rst),
      .dec_io       (dec_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          win[$];
   logic [15:0] m_q[$];
   bit          m_ovr;
   int          m_charge;
   bit          m_cov;
   logic [15:0] m_prev;

   function automatic logic [15:0] floor_avg(input int s);
      int a;
      if (s >= 0) a = s / N;
      else a = -((-s + N - 1) / N);
      return a[15:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         win.delete();
         m_q.delete();
         m_ovr    = 1'b0;
         m_charge = 0;
         m_cov    = 1'b0;
         m_prev   = 16'h0000;
      end else begin
         bit          do_pop;
         bit          do_push;
         logic [15:0] avg;
         int          s;
         do_pop  = (m_q.size() > 0) && dec_if.out_ready;
         do_push = 1'b0;
         avg     = '0;
         if (dec_if.sample_valid) begin
            win.push_back(int'($signed(dec_if.sample_in)));
            if (ChEn) begin
               m_charge = m_charge + $countones(dec_if.sample_in ^ m_prev) * WGT;
               if (m_charge > 20'hFFFFF) m_charge = 20'hFFFFF;
               if (m_charge > LIMIT) m_cov = 1'b1;
            end
            m_prev = dec_if.sample_in;
            if (win.size() == N) begin
               s = 0;
               foreach (win[i]) s += win[i];
               avg     = floor_avg(s);
               do_push = 1'b1;
               win.delete();
            end
         end
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            if (m_q.size() < 2) m_q.push_back(avg);
            else m_ovr = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [15:0] pops[$];
   int          vcycles;

   always @(negedge clk) begin
      check("out_valid", {31'd0, dec_if.out_valid}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) check("out_data", {16'd0, dec_if.out_data}, {16'd0, m_q[0]});
      check("out_overrun", {31'd0, dec_if.out_overrun}, {31'd0, m_ovr});
      check("charge", {12'd0, dec_if.charge}, m_charge);
      check("charge_ovr", {31'd0, dec_if.charge_ovr}, {31'd0, m_cov});
      if (dec_if.out_valid) vcycles++;
      if (dec_if.out_valid && dec_if.out_ready) pops.push_back(dec_if.out_data);
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [15:0] v);
      dec_if.sample_in    = v;
      dec_if.sample_valid = 1'b1;
      @(posedge clk);
      #1;
      dec_if.sample_valid = 1'b0;
   endtask

   task automatic send_n(input int n, input logic [15:0] v);
      for (int i = 0; i < n; i++) send(v);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pops.delete();
      vcycles = 0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, dec_if.out_valid}, 32'd0);
      check({tag, "_data"}, {16'd0, dec_if.out_data}, 32'd0);
      check({tag, "_overrun"}, {31'd0, dec_if.out_overrun}, 32'd0);
      check({tag, "_charge"}, {12'd0, dec_if.charge}, 32'd0);
      check({tag, "_cov"}, {31'd0, dec_if.charge_ovr}, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst                 = 1'b1;
      dec_if.sample_in    = '0;
      dec_if.sample_valid = 1'b0;
      dec_if.out_ready    = 1'b1;
      vcycles             = 0;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b0;

      // Plain average, single-cycle valid with ready high.
      pops.delete();
      vcycles = 0;
      send_n(8, 16'h0100);
      idle(3);
      check("avg_count", pops.size(), 32'd1);
      check("avg_value", {16'd0, pops[0]}, 32'h0100);
      check("avg_vcycles", vcycles, 32'd1);

      // Floor rounding and extremes.
      pops.delete();
      send_n(7, 16'h0000);
      send(16'hFFFF);
      send_n(8, 16'h7FFF);
      send_n(8, 16'h8000);
      idle(3);
      check("floor_count", pops.size(), 32'd3);
      check("floor_neg1", {16'd0, pops[0]}, 32'hFFFF);
      check("max_pos", {16'd0, pops[1]}, 32'h7FFF);
      check("max_neg", {16'd0, pops[2]}, 32'h8000);

      // Backpressure: third result dropped.
      reset_dut();
      dec_if.out_ready = 1'b0;
      send_n(8, 16'h0001);
      send_n(8, 16'h0002);
      send_n(8, 16'h0003);
      idle(2);
      check("bp_overrun", {31'd0, dec_if.out_overrun}, 32'd1);
      check("bp_head", {16'd0, dec_if.out_data}, 32'h0001);
      dec_if.out_ready = 1'b1;
      idle(4);
      check("bp_pops", pops.size(), 32'd2);
      check("bp_pop0", {16'd0, pops[0]}, 32'h0001);
      check("bp_pop1", {16'd0, pops[1]}, 32'h0002);
      check("bp_drained", {31'd0, dec_if.out_valid}, 32'd0);

      // Pop in the same cycle as the push into a full buffer: no drop.
      reset_dut();
      dec_if.out_ready = 1'b0;
      send_n(8, 16'h0001);
      send_n(8, 16'h0002);
      send_n(7, 16'h0003);
      dec_if.out_ready = 1'b1;
      send(16'h0003);
      dec_if.out_ready = 1'b0;
      check("pp_overrun", {31'd0, dec_if.out_overrun}, 32'd0);
      check("pp_head", {16'd0, dec_if.out_data}, 32'h0002);
      dec_if.out_ready = 1'b1;
      idle(4);
      check("pp_pops", pops.size(), 32'd3);
      check("pp_pop2", {16'd0, pops[2]}, 32'h0003);

      // Asynchronous reset mid-window with a result buffered.
      reset_dut();
      dec_if.out_ready = 1'b0;
      send_n(8, 16'h0005);
      send_n(5, 16'h1234);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      dec_if.out_ready = 1'b1;
      pops.delete();
      send_n(8, 16'h0010);
      idle(3);
      check("midrst_count", pops.size(), 32'd1);
      check("midrst_value", {16'd0, pops[0]}, 32'h0010);

      // Charge accounting.
      reset_dut();
      send(16'h0000);
      check("charge_0", {12'd0, dec_if.charge}, 32'd0);
      send(16'hFFFF);
      check("charge_48", {12'd0, dec_if.charge}, ChEn ? 32'd48 : 32'd0);
      send(16'h0000);
      check("charge_96", {12'd0, dec_if.charge}, ChEn ? 32'd96 : 32'd0);

      reset_dut();
      for (int i = 0; i < 20833; i++) send((i % 2 == 0) ? 16'hFFFF : 16'h0000);
      check("cov_below", {31'd0, dec_if.charge_ovr}, 32'd0);
      check("charge_below", {12'd0, dec_if.charge}, ChEn ? 32'd999984 : 32'd0);
      send(16'h0000);
      check("cov_set", {31'd0, dec_if.charge_ovr}, {31'd0, ChEn});
      check("charge_over", {12'd0, dec_if.charge}, ChEn ? 32'd1000032 : 32'd0);
      for (int i = 0; i < 1200; i++) send((i % 2 == 0) ? 16'hFFFF : 16'h0000);
      check("charge_sat", {12'd0, dec_if.charge}, ChEn ? 32'hFFFFF : 32'd0);
      check("cov_sticky", {31'd0, dec_if.charge_ovr}, {31'd0, ChEn});
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
